// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: money width, tube indices,
// payout FSM encoding and a small saturating-increment helper.
package vending_pkg;

    localparam int MONEY_W   = 6;
    localparam int NUM_TUBES = 4;

    // Tube indices, lowest-value tube first
    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        FIRE,
        WAIT_ACK,
        DONE,
        FAULT
    } disp_state_t;

    // Count up by one, sticking at the all-ones value
    function automatic logic [MONEY_W-1:0] sat_inc(input logic [MONEY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the change request, status and coin-hopper signals.
// master = the surrounding machine/hopper, slave = the dispenser.
interface change_dispenser_if;

    logic [vending_pkg::MONEY_W-1:0] change_in;
    logic                            change_valid;
    logic                            clear_fault;
    logic [3:0]                      hopper_empty;
    logic                            hopper_ack;
    logic [1:0]                      hopper_sel;
    logic                            hopper_fire;
    logic                            busy;
    logic                            done;
    logic                            fault;
    logic [vending_pkg::MONEY_W-1:0] remaining;
    logic [vending_pkg::MONEY_W-1:0] coin_count;

    modport master (
        output change_in, change_valid, clear_fault, hopper_empty, hopper_ack,
        input  hopper_sel, hopper_fire, busy, done, fault, remaining, coin_count
    );

    modport slave (
        input  change_in, change_valid, clear_fault, hopper_empty, hopper_ack,
        output hopper_sel, hopper_fire, busy, done, fault, remaining, coin_count
    );

endinterface

// File: rtl/hopper_timer.sv
// Shared 8-bit down-counter: times the eject pulse and the ack window.
// expired is high during the last counted cycle of the loaded interval.
module hopper_timer #(
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_pulse,
    input  logic load_ack,
    output logic expired
);

    logic [7:0] count_reg;

    // Load on phase entry, then count down and rest at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load_pulse) begin
            count_reg <= 8'(PULSE_CYC);
        end else if (load_ack) begin
            count_reg <= 8'(ACK_TIMEOUT);
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign expired = (count_reg == 8'd1);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout stage: pays a change amount coin by coin, largest usable
// tube first, skipping empty tubes and faulting on a missing hopper ack.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int VAL_D3      = 10,
    parameter int VAL_D2      = 5,
    parameter int VAL_D1      = 2,
    parameter int VAL_D0      = 1,
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset_n,
    change_dispenser_if.slave bus
);

    disp_state_t          state_reg, state_next;
    logic [MONEY_W-1:0]   remaining_reg, remaining_next;
    logic [MONEY_W-1:0]   coin_count_reg, coin_count_next;
    logic [1:0]           sel_reg, sel_next;
    logic                 fire_reg, busy_reg, done_reg, fault_reg;
    logic                 load_pulse, load_ack, timer_expired;
    logic [MONEY_W-1:0]   tube_val [NUM_TUBES];
    logic [NUM_TUBES-1:0] qualify;
    logic                 pick_valid;
    logic [1:0]           pick_tube;

    assign tube_val[D0] = MONEY_W'(VAL_D0);
    assign tube_val[D1] = MONEY_W'(VAL_D1);
    assign tube_val[D2] = MONEY_W'(VAL_D2);
    assign tube_val[D3] = MONEY_W'(VAL_D3);

    // A tube can pay if it holds coins and its coin does not overshoot
    for (genvar gi = 0; gi < NUM_TUBES; gi++) begin : g_qualify
        assign qualify[gi] = !bus.hopper_empty[gi] && (tube_val[gi] <= remaining_reg);
    end

    // Highest qualifying tube wins (later iterations override earlier ones)
    always_comb begin
        pick_valid = 1'b0;
        pick_tube  = D0;
        for (int d = 0; d < NUM_TUBES; d++) begin
            if (qualify[d]) begin
                pick_valid = 1'b1;
                pick_tube  = 2'(d);
            end
        end
    end

    hopper_timer #(
        .PULSE_CYC  (PULSE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_pulse(load_pulse),
        .load_ack  (load_ack),
        .expired   (timer_expired)
    );

    // Next-state and datapath decisions
    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        coin_count_next = coin_count_reg;
        sel_next        = sel_reg;
        load_pulse      = 1'b0;
        load_ack        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.change_valid) begin
                    if (bus.change_in != '0) begin
                        remaining_next  = bus.change_in;
                        coin_count_next = '0;
                        state_next      = SELECT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SELECT: begin
                if (pick_valid) begin
                    sel_next   = pick_tube;
                    load_pulse = 1'b1;
                    state_next = FIRE;
                end else begin
                    state_next = FAULT;
                end
            end
            FIRE: begin
                if (timer_expired) begin
                    load_ack   = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack on the final timeout cycle still counts
                if (bus.hopper_ack) begin
                    remaining_next  = remaining_reg - tube_val[sel_reg];
                    coin_count_next = sat_inc(coin_count_reg);
                    state_next      = (remaining_next == '0) ? DONE : SELECT;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (bus.clear_fault) begin
                    remaining_next = '0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            coin_count_reg <= '0;
            sel_reg        <= '0;
            fire_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            coin_count_reg <= coin_count_next;
            sel_reg        <= sel_next;
            fire_reg       <= (state_next == FIRE);
            busy_reg       <= (state_next == SELECT) || (state_next == FIRE) ||
                              (state_next == WAIT_ACK);
            done_reg       <= (state_next == DONE);
            fault_reg      <= (state_next == FAULT);
        end
    end

    assign bus.hopper_sel  = sel_reg;
    assign bus.hopper_fire = fire_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.fault       = fault_reg;
    assign bus.remaining   = remaining_reg;
    assign bus.coin_count  = coin_count_reg;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream payout stage of the vending machine. Accepts the 6-bit change amount the vending controller produces at the end of a transaction and pays it out as individual coins through a four-tube coin hopper. Uses a largest-coin-first policy, skips empty tubes, and times out missing hopper acknowledges. It reports completion, or a fault with the undispensed balance.

## Interface
Parameters:
- VAL_D3, 10: value of tube 3 coin
- VAL_D2, 5: value of tube 2 coin
- VAL_D1, 2: value of tube 1 coin
- VAL_D0, 1: value of tube 0 coin
- PULSE_CYC, 4: hopper_fire high time in cycles (1..15)
- ACK_TIMEOUT, 255: max cycles waiting for hopper_ack (1..255)

Ports:
- clk, in, 1: single clock, rising edge
- reset_n, in, 1: asynchronous, active-low reset
- change_in, in, 6: change amount from the vending controller, 0..63
- change_valid, in, 1: one-cycle strobe qualifying change_in
- clear_fault, in, 1: leave FAULT
- hopper_empty, in, 4: bit d set means tube d is empty
- hopper_ack, in, 1: one-cycle pulse, coin physically ejected
- hopper_sel, out, 2: tube index being fired
- hopper_fire, out, 1: eject command
- busy, out, 1: dispense in progress
- done, out, 1: one-cycle pulse, full change paid
- fault, out, 1: held high while in FAULT
- remaining, out, 6: balance still to pay
- coin_count, out, 6: coins ejected in the current/last transaction

## Operation
- FSM states: IDLE, SELECT, FIRE, WAIT_ACK, DONE, FAULT.
- IDLE:
  - change_valid with change_in ≠ 0: latch remaining = change_in, clear coin_count, go to SELECT.
  - change_valid with change_in = 0: go to DONE.
- SELECT: choose the highest d where VAL_Dd ≤ remaining and hopper_empty[d] = 0.
  - If a tube qualifies: register hopper_sel = d, go to FIRE.
  - If none qualifies: go to FAULT.
- FIRE: hopper_fire = 1 for exactly PULSE_CYC cycles, then go to WAIT_ACK. hopper_ack is ignored in FIRE.
- WAIT_ACK:
  - hopper_ack: remaining -= VAL_D[hopper_sel] and coin_count += 1. If the new remaining = 0, go to DONE; otherwise go to SELECT.
  - No ack within ACK_TIMEOUT cycles: go to FAULT, remaining unchanged.
- DONE: done = 1 for one cycle, then go to IDLE.
- FAULT:
  - fault = 1 and busy = 0; remaining holds the unpaid balance.
  - clear_fault: go to IDLE, remaining cleared to 0.
- Tube status: hopper_empty is sampled only in SELECT. A tube going empty mid-pulse does not abort the coin in flight.
- Ignored inputs: change_valid is ignored in every state except IDLE. clear_fault is ignored outside FAULT.
- Arithmetic: subtraction is 6-bit and can never underflow, because SELECT guarantees VAL ≤ remaining. coin_count saturates at 63.
- busy = 1 in SELECT, FIRE and WAIT_ACK.

## Timing
- All outputs are registered.
- Reset values: IDLE state; hopper_sel, hopper_fire, busy, done, fault, remaining and coin_count all 0.
- Reset asserted mid-dispense: all outputs return to reset values immediately; the transaction is lost.
- change_valid sampled at edge k: SELECT at k+1, hopper_fire high from k+2 through k+1+PULSE_CYC.
- Per-coin minimum: 1 + PULSE_CYC + 1 cycles.
- Ack sampled at edge j: remaining and coin_count update at j+1; done is high at j+1 when remaining reaches 0.
- Zero change: done is high one cycle after change_valid; hopper_fire never asserts.
- Timeout: FAULT is entered on the ACK_TIMEOUT-th consecutive WAIT_ACK cycle without an ack.
- Simultaneous ack and timeout: the ack wins.

## Structure
- vending_pkg holds:
  - FSM state encoding
  - tube index constants D0..D3
  - shared width constant MONEY_W = 6, also used by the vending controller
- Sub-module hopper_timer, one 8-bit down-counter:
  - loads PULSE_CYC on entry to FIRE and ACK_TIMEOUT on entry to WAIT_ACK
  - flags expiry to the FSM
- change_dispenser holds the FSM, the remaining/coin_count datapath and the greedy selector.

## Test plan
- change_in = 17, all tubes full, ack 2 cycles after each fire falls → tubes fired 3, 2, 1 (10+5+2); done; coin_count = 3; remaining = 0.
- change_in = 63 → tube 3 ×6, then tube 1, then tube 0; coin_count = 8; done.
- hopper_empty = 4'b1000, change_in = 20 → tube 2 ×4; done.
- hopper_empty = 4'b0011 (tubes 1 and 0 empty), change_in = 8 → tube 2 ×1, then FAULT with remaining = 3 and fault = 1; clear_fault returns to IDLE.
- change_in = 5, hopper_ack withheld → FAULT exactly ACK_TIMEOUT cycles after WAIT_ACK entry, remaining = 5. Separately, reset_n pulsed low during FIRE → hopper_fire drops immediately and all outputs are 0.
- change_in = 0 → done next cycle, no hopper_fire. A second change_valid while busy is ignored, and the original amount completes.
